// File: rtl/onewire_slave.sv
// 1-wire slave: reset/presence handling, Skip ROM, function-command capture and
// Read Scratchpad returning a 16-bit temperature word LSB-first.
module onewire_slave #(
  parameter int CLK_PER_US  = 16,
  parameter int RST_MIN_US  = 480,
  parameter int PRES_DLY_US = 30,
  parameter int PRES_LEN_US = 120,
  parameter int SAMPLE_US   = 30,
  parameter int TX0_LEN_US  = 45
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [15:0] temp_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy
);

  localparam logic [15:0] RST_CYC    = 16'(RST_MIN_US * CLK_PER_US);
  localparam logic [15:0] PRES_DLY_C = 16'(PRES_DLY_US * CLK_PER_US);
  localparam logic [15:0] PRES_LEN_C = 16'(PRES_LEN_US * CLK_PER_US);
  localparam logic [15:0] SAMPLE_C   = 16'(SAMPLE_US * CLK_PER_US);
  localparam logic [15:0] TX0_C      = 16'(TX0_LEN_US * CLK_PER_US);
  localparam logic [7:0]  CMD_SKIP   = 8'hCC;
  localparam logic [7:0]  CMD_READ   = 8'hBE;

  typedef enum logic [2:0] {
    IDLE, RST_LOW, PRES_WAIT, PRES_DRIVE, RX_ROM, RX_FUNC, TX_TEMP, WAIT_RST
  } state_t;

  state_t      state_reg;
  logic        sync1_reg;
  logic        dq_s;
  logic        dq_prev_reg;
  logic [15:0] low_cnt_reg;
  logic [15:0] tmr_reg;
  logic        slot_busy_reg;
  logic [4:0]  bit_cnt_reg;
  logic [7:0]  rx_sh_reg;
  logic [15:0] tx_sh_reg;

  logic       fall;
  logic       rise;
  logic       rst_det;
  logic [7:0] rx_byte;

  assign fall    = dq_prev_reg & ~dq_s;
  assign rise    = ~dq_prev_reg & dq_s;
  // Fires on the one cycle the low-time counter steps onto the threshold.
  assign rst_det = ~dq_s & ~fall & (low_cnt_reg == RST_CYC - 16'd1);
  assign rx_byte = {dq_s, rx_sh_reg[7:1]};

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sync1_reg     <= 1'b1;
      dq_s          <= 1'b1;
      dq_prev_reg   <= 1'b1;
      low_cnt_reg   <= '0;
      tmr_reg       <= '0;
      slot_busy_reg <= 1'b0;
      bit_cnt_reg   <= '0;
      rx_sh_reg     <= '0;
      tx_sh_reg     <= '0;
      dq_oe         <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_byte      <= '0;
      busy          <= 1'b0;
    end else begin
      sync1_reg   <= dq_in;
      dq_s        <= sync1_reg;
      dq_prev_reg <= dq_s;
      cmd_valid   <= 1'b0;

      if (fall)
        low_cnt_reg <= '0;
      else if (!dq_s && low_cnt_reg != 16'hFFFF)
        low_cnt_reg <= low_cnt_reg + 16'd1;

      if (rst_det) begin
        state_reg     <= RST_LOW;
        dq_oe         <= 1'b0;
        bit_cnt_reg   <= '0;
        rx_sh_reg     <= '0;
        slot_busy_reg <= 1'b0;
        tmr_reg       <= '0;
        busy          <= 1'b1;
      end else begin
        case (state_reg)
          IDLE, WAIT_RST: dq_oe <= 1'b0;
          RST_LOW: begin
            if (rise) begin
              state_reg <= PRES_WAIT;
              tmr_reg   <= '0;
            end
          end
          PRES_WAIT: begin
            if (tmr_reg == PRES_DLY_C - 16'd1) begin
              state_reg <= PRES_DRIVE;
              dq_oe     <= 1'b1;
              tmr_reg   <= '0;
            end else begin
              tmr_reg <= tmr_reg + 16'd1;
            end
          end
          PRES_DRIVE: begin
            if (tmr_reg == PRES_LEN_C - 16'd1) begin
              state_reg     <= RX_ROM;
              dq_oe         <= 1'b0;
              tmr_reg       <= '0;
              slot_busy_reg <= 1'b0;
            end else begin
              tmr_reg <= tmr_reg + 16'd1;
            end
          end
          RX_ROM, RX_FUNC: begin
            if (slot_busy_reg) begin
              if (tmr_reg == SAMPLE_C - 16'd1) begin
                slot_busy_reg <= 1'b0;
                rx_sh_reg     <= rx_byte;
                bit_cnt_reg   <= bit_cnt_reg + 5'd1;
                if (bit_cnt_reg == 5'd7) begin
                  bit_cnt_reg <= '0;
                  if (state_reg == RX_ROM) begin
                    state_reg <= (rx_byte == CMD_SKIP) ? RX_FUNC : WAIT_RST;
                  end else begin
                    cmd_byte  <= rx_byte;
                    cmd_valid <= 1'b1;
                    if (rx_byte == CMD_READ) begin
                      tx_sh_reg <= temp_data;
                      state_reg <= TX_TEMP;
                    end else begin
                      state_reg <= WAIT_RST;
                    end
                  end
                end
              end else begin
                tmr_reg <= tmr_reg + 16'd1;
              end
            end else if (fall) begin
              slot_busy_reg <= 1'b1;
              tmr_reg       <= '0;
            end
          end
          TX_TEMP: begin
            // The slot timer runs for the 0-bit hold window on every bit,
            // so falls caused by our own drive are never taken as new slots.
            if (slot_busy_reg) begin
              if (tmr_reg == TX0_C - 16'd1) begin
                slot_busy_reg <= 1'b0;
                dq_oe         <= 1'b0;
                if (bit_cnt_reg == 5'd16)
                  state_reg <= WAIT_RST;
              end else begin
                tmr_reg <= tmr_reg + 16'd1;
              end
            end else if (fall) begin
              slot_busy_reg <= 1'b1;
              tmr_reg       <= '0;
              dq_oe         <= ~tx_sh_reg[0];
              tx_sh_reg     <= tx_sh_reg >> 1;
              bit_cnt_reg   <= bit_cnt_reg + 5'd1;
            end
          end
          default: begin
            state_reg <= IDLE;
            dq_oe     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: a bus master model on a wired-AND line, table-driven
// and randomized transactions checked against a transaction-level expectation.
`timescale 1ns/1ps
module tb_onewire_slave;
  localparam int US       = 2;
  localparam int PRES_DLY = 30 * US;
  localparam int PRES_LEN = 120 * US;
  localparam int TX0      = 45 * US;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        master_low = 1'b0;
  logic [15:0] temp_data = 16'h0000;
  logic        dq_in;
  logic        dq_oe;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        busy;

  assign dq_in = ~(master_low | dq_oe);

  always #5 clk_in = ~clk_in;

  onewire_slave #(.CLK_PER_US(US)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .dq_in(dq_in), .dq_oe(dq_oe),
    .temp_data(temp_data), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .busy(busy)
  );

  int   cyc = 0;
  int   valid_cnt = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   oe_len = 0;
  logic oe_prev = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    oe_prev <= dq_oe;
    if (cmd_valid) valid_cnt <= valid_cnt + 1;
    if (dq_oe && !oe_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (!dq_oe && oe_prev) oe_len <= cyc - rise_cyc;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic reset_pulse(int low_us, output int rel_cyc);
    master_low = 1'b1;
    tick(low_us * US);
    master_low = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic write_bit(bit b);
    master_low = 1'b1;
    tick((b ? 5 : 60) * US);
    master_low = 1'b0;
    tick((b ? 65 : 10) * US);
  endtask

  task automatic write_byte(logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output bit b);
    master_low = 1'b1;
    tick(2 * US);
    master_low = 1'b0;
    tick(13 * US);
    b = dq_in;
    tick(55 * US);
  endtask

  // Reset + presence, checking the presence pulse timing.
  task automatic do_reset_presence(string tag);
    int rel;
    int r0;
    r0 = rise_cnt;
    reset_pulse(481, rel);
    tick(200 * US);
    check({tag, "_pres_count"}, rise_cnt - r0, 1);
    check_range({tag, "_pres_delay"}, rise_cyc - rel, PRES_DLY + 2, PRES_DLY + 3);
    check({tag, "_pres_len"}, oe_len, PRES_LEN);
    check({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic run_txn(int idx, logic [7:0] rom, logic [7:0] func, logic [15:0] temp,
                         int exp_cnt, logic [7:0] exp_cmd, logic [15:0] exp_word);
    int v0;
    int r1;
    bit b;
    logic [15:0] word;
    temp_data = temp;
    v0 = valid_cnt;
    do_reset_presence("txn");
    write_byte(rom);
    write_byte(func);
    check("cmd_valid_pulses", valid_cnt - v0, exp_cnt);
    check("cmd_byte", int'(cmd_byte), int'(exp_cmd));
    r1 = rise_cnt;
    word = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      read_bit(b);
      word[i] = b;
      if (i == 0) temp_data = ~temp;
      if (!b) check("zero_hold", oe_len, TX0);
    end
    check("read_word", int'(word), int'(exp_word));
    check("tx_drive_count", rise_cnt - r1, 16 - $countones(exp_word));
    check("busy_after", int'(busy), 1);
    $display("txn %0d rom=%h func=%h temp=%h cmd=%h word=%h", idx, rom, func, temp, cmd_byte, word);
  endtask

  typedef struct {
    logic [7:0]  rom;
    logic [7:0]  func;
    logic [15:0] temp;
    int          exp_cnt;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_word;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int rel;
    int r0;
    int v0;
    int n;
    bit b;
    logic [7:0]  model_cmd;
    logic [7:0]  rom;
    logic [7:0]  func;
    logic [15:0] temp;
    logic [15:0] word;

    tbl[0] = '{8'hCC, 8'h44, 16'h0191, 1, 8'h44, 16'hFFFF};
    tbl[1] = '{8'hCC, 8'hBE, 16'h0191, 1, 8'hBE, 16'h0191};
    tbl[2] = '{8'h33, 8'hBE, 16'h1234, 0, 8'hBE, 16'hFFFF};
    tbl[3] = '{8'hCC, 8'hA5, 16'h5A5A, 1, 8'hA5, 16'hFFFF};
    tbl[4] = '{8'hCC, 8'hBE, 16'h0000, 1, 8'hBE, 16'h0000};

    tick(5);
    check("rst_dq_oe", int'(dq_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_cmd_byte", int'(cmd_byte), 0);
    rst_n = 1'b1;
    tick(20);

    // Too-short low pulse must be ignored.
    r0 = rise_cnt;
    reset_pulse(470, rel);
    tick(300 * US);
    check("short_low_no_presence", rise_cnt - r0, 0);
    check("short_low_busy", int'(busy), 0);
    $display("txn short_low presence_edges=%0d busy=%0b", rise_cnt - r0, busy);

    for (int i = 0; i < 5; i++)
      run_txn(i, tbl[i].rom, tbl[i].func, tbl[i].temp, tbl[i].exp_cnt, tbl[i].exp_cmd, tbl[i].exp_word);

    // Randomized transactions against the transaction-level model.
    model_cmd = 8'hBE;
    for (int i = 0; i < 4; i++) begin
      rom = ($urandom_range(0, 3) != 0) ? 8'hCC : 8'($urandom);
      case ($urandom_range(0, 2))
        0: func = 8'hBE;
        1: func = 8'h44;
        default: func = 8'($urandom);
      endcase
      temp = 16'($urandom);
      if (rom == 8'hCC) model_cmd = func;
      run_txn(5 + i, rom, func, temp, (rom == 8'hCC) ? 1 : 0, model_cmd,
              (rom == 8'hCC && func == 8'hBE) ? temp : 16'hFFFF);
    end

    // Reset pulse arriving in the 5th read slot.
    temp_data = 16'h0191;
    do_reset_presence("mid_tx");
    write_byte(8'hCC);
    write_byte(8'hBE);
    word = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      read_bit(b);
      word[i] = b;
    end
    check("mid_tx_first_nibble", int'(word[3:0]), 1);
    r0 = rise_cnt;
    reset_pulse(481, rel);
    check("mid_tx_oe_released", int'(dq_oe), 0);
    tick(200 * US);
    check("mid_tx_represence", rise_cnt - r0, 1);
    check("mid_tx_pres_len", oe_len, PRES_LEN);
    v0 = valid_cnt;
    write_byte(8'hCC);
    write_byte(8'h44);
    check("mid_tx_new_cmd", int'(cmd_byte), 8'h44);
    check("mid_tx_new_valid", valid_cnt - v0, 1);
    $display("txn mid_tx_reset nibble=%h cmd=%h", word[3:0], cmd_byte);

    // rst_n asserted while the presence pulse is being driven.
    reset_pulse(481, rel);
    n = 0;
    while (!dq_oe && n < 200 * US) begin
      tick(1);
      n++;
    end
    check("pres_drive_reached", int'(dq_oe), 1);
    tick(20);
    rst_n = 1'b0;
    tick(1);
    check("rst_n_oe_release", int'(dq_oe), 0);
    check("rst_n_busy", int'(busy), 0);
    rst_n = 1'b1;
    r0 = rise_cnt;
    tick(200 * US);
    check("rst_n_no_presence", rise_cnt - r0, 0);
    check("rst_n_idle_busy", int'(busy), 0);
    $display("txn rst_n_in_presence dq_oe=%0b busy=%0b", dq_oe, busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onewire_slave.md
ONEWIRE_SLAVE -- requirements
Module: onewire_slave

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 16, meaning clk_in cycles per microsecond (16.384 MHz system clock, truncated).
REQ-002 SHALL have parameter RST_MIN_US, default 480, meaning the minimum bus-low time recognised as a reset pulse.
REQ-003 SHALL have parameter PRES_DLY_US, default 30, meaning the delay from reset-pulse release to the start of the presence pulse.
REQ-004 SHALL have parameter PRES_LEN_US, default 120, meaning the presence pulse length.
REQ-005 SHALL have parameter SAMPLE_US, default 30, meaning the delay from a slot's falling edge to the slave's sample point.
REQ-006 SHALL have parameter TX0_LEN_US, default 45, meaning the hold-low time when the slave transmits a 0 bit.
REQ-007 SHALL have port clk_in, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port dq_in, input, 1 bit: raw 1-wire bus level, asynchronous to clk_in.
REQ-010 SHALL have port dq_oe, output, 1 bit: when 1, the pad drives the bus low; when 0, the bus is released.
REQ-011 SHALL have port temp_data, input, 16 bits: the temperature word returned by Read Scratchpad.
REQ-012 SHALL have port cmd_valid, output, 1 bit: one-cycle pulse when a function command byte is received.
REQ-013 SHALL have port cmd_byte, output, 8 bits: the last received function command; holds its value between pulses.
REQ-014 SHALL have port busy, output, 1 bit: high from reset-pulse recognition until the block returns to IDLE.

Function
REQ-015 SHALL synchronise dq_in through a two-flop synchroniser; all timing and edge detection SHALL use the second-stage output (dq_s).
REQ-016 SHALL detect a falling edge as dq_s==0 while the previous dq_s==1, and a rising edge as the converse.
REQ-017 SHALL maintain a 16-bit low-time counter that clears on every falling edge, increments while dq_s==0, and saturates at 0xFFFF.
REQ-018 SHALL recognise a reset pulse when the low-time counter reaches RST_MIN_US*CLK_PER_US, in any state; the block SHALL then set dq_oe=0, clear the bit and byte counters, enter RST_LOW, and set busy=1.
REQ-019 SHALL use states IDLE, RST_LOW, PRES_WAIT, PRES_DRIVE, RX_ROM, RX_FUNC, TX_TEMP, and WAIT_RST.
REQ-020 SHALL transition RST_LOW->PRES_WAIT on a rising edge; PRES_WAIT->PRES_DRIVE after PRES_DLY_US*CLK_PER_US cycles, with dq_oe=1; PRES_DRIVE->RX_ROM after PRES_LEN_US*CLK_PER_US cycles, with dq_oe=0.
REQ-021 SHALL, in receive states, on each falling edge start a slot timer and sample dq_s at exactly SAMPLE_US*CLK_PER_US cycles; bits SHALL be shifted LSB-first into an 8-bit register.
REQ-022 SHALL, after the 8th bit in RX_ROM: if the byte is 0xCC (Skip ROM), go to RX_FUNC; otherwise go to WAIT_RST.
REQ-023 SHALL, after the 8th bit in RX_FUNC: latch cmd_byte, pulse cmd_valid for exactly one cycle, then:
  - 0xBE: capture temp_data into a 16-bit shift register and go to TX_TEMP;
  - any other value: go to WAIT_RST.
REQ-024 SHALL, in TX_TEMP, on each falling edge output the current LSB: for a 0, dq_oe=1 from the cycle after the edge is detected until TX0_LEN_US*CLK_PER_US cycles have elapsed; for a 1, dq_oe stays 0.
REQ-025 SHALL, after 16 transmitted bits, go to WAIT_RST; temp_data changes during TX_TEMP SHALL NOT affect the transmitted word.
REQ-026 SHALL stay in WAIT_RST with dq_oe=0 and ignore slots until a reset pulse; IDLE behaves the same, with busy=0.
REQ-027 SHALL ignore falling edges occurring while a slot timer is still running.
REQ-028 SHALL give a reset pulse recognised mid-slot or mid-transmit priority over all other activity, including releasing any 0-bit drive in the same cycle.
REQ-029 SHALL assert dq_oe only in PRES_DRIVE and during TX_TEMP 0-bit windows.

Reset
REQ-030 SHALL, on a clk_in rising edge with rst_n==0, set: state=IDLE, dq_oe=0, cmd_valid=0, cmd_byte=0x00, busy=0, all counters and shift registers 0, and both synchroniser stages 1.
REQ-031 SHALL, when rst_n is asserted mid-presence or mid-transmit, release dq_oe on that same edge.

Verification
REQ-032 SHALL be tested: bus low 480 us then released -> dq_oe rises 30 us (+sync latency) after release and stays high for 120 us; busy=1.
REQ-033 SHALL be tested: bus low 470 us -> no presence pulse, busy stays 0.
REQ-034 SHALL be tested: reset, presence, master writes 0xCC then 0x44 (1-slots low 5 us, 0-slots low 60 us, 70 us period) -> one cmd_valid pulse, cmd_byte=0x44, state WAIT_RST, no further dq_oe.
REQ-035 SHALL be tested: temp_data=0x0191, reset, 0xCC, 0xBE, then 16 read slots (low 2 us) with the bench sampling at 15 us -> bits read LSB-first reconstruct 0x0191, each 0 bit held low 45 us.
REQ-036 SHALL be tested: ROM byte 0x33 -> WAIT_RST, subsequent slots never drive dq_oe; a following reset pulse produces presence again.
REQ-037 SHALL be tested: reset pulse issued during the 5th TX_TEMP bit, and separately rst_n=0 during PRES_DRIVE -> dq_oe=0 immediately; the block re-enters presence (first case) or IDLE (second case).
